// File: rtl/inst_mem_ctrl.sv
// Instruction memory with a valid/ready program loader and a reset-time clear sweep.
// Fetch reads are combinational (REG_OUT=0) or registered with one cycle of latency (REG_OUT=1).
module inst_mem_ctrl #(
  parameter int              XLEN    = 32,
  parameter int              IW      = 32,
  parameter int              DEPTH   = 128,
  parameter int              AW      = $clog2(DEPTH),
  parameter int              REG_OUT = 0,
  parameter logic [IW-1:0]   NOP     = 32'h00000013
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_pc,
  output logic [IW-1:0]   o_inst,
  output logic            o_inst_valid,
  output logic            o_fetch_fault,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic            i_ld_auto,
  input  logic [AW-1:0]   i_ld_addr,
  input  logic [IW-1:0]   i_ld_data,
  output logic [AW-1:0]   o_ld_ptr,
  output logic            o_ld_wrap,
  output logic            o_busy
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_sweep;
  logic [AW-1:0] r_ptr;
  logic          r_wrap;
  logic [IW-1:0] r_mem [DEPTH];

  logic          w_busy;
  logic          w_ready;
  logic          w_xfer;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_idx;
  logic          w_fault;
  logic          w_run;
  logic [IW-1:0] w_inst;
  logic          w_valid;
  logic          w_fflt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= CLEAR;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_ready = 1'b0;
    case (r_state)
      CLEAR: begin
        w_busy = 1'b1;
        if (r_sweep == AW'(DEPTH - 1)) w_next = RUN;
      end
      RUN:     w_ready = 1'b1;
      default: w_next = CLEAR;
    endcase
  end

  assign w_xfer  = i_ld_valid && w_ready;
  assign w_waddr = i_ld_auto ? r_ptr : i_ld_addr;

  always_ff @(posedge i_clk) begin
    if (!i_rst)      r_sweep <= '0;
    else if (w_busy) r_sweep <= r_sweep + 1'b1;
  end

  // Single write port: the sweep owns it in CLEAR, the loader in RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (w_busy)      r_mem[r_sweep] <= '0;
      else if (w_xfer) r_mem[w_waddr] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ptr  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_xfer && i_ld_auto && (r_ptr == AW'(DEPTH - 1));
      if (w_xfer && i_ld_auto) r_ptr <= r_ptr + 1'b1;
    end
  end

  assign w_idx   = i_pc[AW+1:2];
  assign w_fault = (i_pc[1:0] != 2'b00) || ((i_pc >> (AW + 2)) != '0);
  assign w_run   = (r_state == RUN);
  assign w_inst  = (w_run && !w_fault) ? r_mem[w_idx] : NOP;
  assign w_valid = w_run && !w_fault;
  assign w_fflt  = w_run && w_fault;

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [IW-1:0] r_inst;
      logic          r_valid;
      logic          r_fflt;

      always_ff @(posedge i_clk) begin
        if (!i_rst) begin
          r_inst  <= NOP;
          r_valid <= 1'b0;
          r_fflt  <= 1'b0;
        end else begin
          r_inst  <= w_inst;
          r_valid <= w_valid;
          r_fflt  <= w_fflt;
        end
      end

      assign o_inst        = r_inst;
      assign o_inst_valid  = r_valid;
      assign o_fetch_fault = r_fflt;
    end else begin : g_comb
      assign o_inst        = w_inst;
      assign o_inst_valid  = w_valid;
      assign o_fetch_fault = w_fflt;
    end
  endgenerate

  assign o_ld_ready = w_ready;
  assign o_busy     = w_busy;
  assign o_ld_ptr   = r_ptr;
  assign o_ld_wrap  = r_wrap;

endmodule
